vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//   Produces the 640x480@60Hz raster timing that the block controller reads:
//   hCount/vCount pixel coordinates, bright (visible area), and active-low hSync/vSync.
//   Divides the 100 MHz system clk down to the 25 MHz pixel rate with a clock-enable (no derived clocks).
//   Also emits per-frame and per-N-frame single-cycle ticks that pace game-state updates.
// PARAMETERS
//   DIV        4    clk cycles per pixel; pix_en pulses once every DIV clk cycles (DIV>=2)
//   H_TOTAL    800  pixels per line; hCount counts 0..H_TOTAL-1
//   H_SYNC     96   hSync low while hCount < H_SYNC
//   H_VIS_LO   144  first visible column (inclusive)
//   H_VIS_HI   783  last visible column (inclusive)
//   V_TOTAL    525  lines per frame; vCount counts 0..V_TOTAL-1
//   V_SYNC     2    vSync low while vCount < V_SYNC
//   V_VIS_LO   35   first visible row (inclusive)
//   V_VIS_HI   514  last visible row (inclusive)
//   FRAME_DIV  1    frames per game_tick (>=1)
// PORTS
//   clk         in   1   system clock, 100 MHz
//   rst         in   1   asynchronous, active-high reset
//   pix_en      out  1   one-clk pulse at pixel rate; counters advance only on it
//   hCount      out  10  horizontal coordinate, 0..H_TOTAL-1
//   vCount      out  10  vertical coordinate, 0..V_TOTAL-1
//   hSync       out  1   horizontal sync, active low
//   vSync       out  1   vertical sync, active low
//   bright      out  1   1 iff H_VIS_LO<=hCount<=H_VIS_HI and V_VIS_LO<=vCount<=V_VIS_HI
//   line_tick   out  1   one-clk pulse when hCount wraps H_TOTAL-1 -> 0
//   frame_tick  out  1   one-clk pulse when (hCount,vCount) wraps (H_TOTAL-1,V_TOTAL-1) -> (0,0)
//   game_tick   out  1   one-clk pulse on every FRAME_DIV-th frame_tick
// BEHAVIOUR
//   Reset (async, any time incl. mid-line): div_cnt=0, hCount=0, vCount=0, frame_cnt=0,
//     pix_en=0, hSync=0, vSync=0, bright=0, line_tick=0, frame_tick=0, game_tick=0.
//   Divider: div_cnt counts 0..DIV-1 and wraps; pix_en registered, high for the single clk
//     cycle after div_cnt==DIV-1. First pix_en is DIV clk edges after reset release.
//   Counters, on clk edge with pix_en=1: hCount==H_TOTAL-1 ? 0 : hCount+1;
//     vCount increments only when hCount wraps; vCount==V_TOTAL-1 wraps to 0 on that edge.
//     With pix_en=0 all counters and sync/bright hold.
//   hSync, vSync, bright are registered, computed from the next-state counter values, and
//     therefore change on the same clk edge as hCount/vCount (zero skew to coordinates).
//   line_tick/frame_tick registered on the wrapping edge; high exactly 1 clk, never 2 back-to-back.
//   frame_cnt counts frame_ticks 0..FRAME_DIV-1; game_tick fires on the edge frame_cnt wraps;
//     FRAME_DIV=1 -> game_tick identical to frame_tick.
//   Simultaneous line and frame wrap: line_tick and frame_tick both pulse in the same cycle.
//   All widths 10 bits; no counter ever exceeds its TOTAL-1 (no overflow path).
//   Periods (defaults): line = 800*4 = 3200 clk; frame = 525*3200 = 1,680,000 clk.
// TESTING
//   1. Release rst, count clk -> pix_en first high at clk 4, then every 4th clk; hCount 0->1 on it.
//   2. Run to hCount=799,vCount=0 -> next pix_en: hCount=0, vCount=1, line_tick=1 for 1 clk.
//   3. Sweep one line at vCount=100 -> hSync=0 for hCount 0..95, 1 for 96..799;
//      bright=0 at 143, 1 at 144 and 783, 0 at 784.
//   4. Check rows at hCount=200 -> bright=0 at vCount 34 and 515, 1 at 35 and 514;
//      vSync=0 only at vCount 0..1.
//   5. Full frames, FRAME_DIV=2 -> frame_tick period 1,680,000 clk, game_tick every 3,360,000 clk,
//      coincident with every second frame_tick.
//   6. Assert rst mid-line at hCount=400,vCount=300 -> all outputs 0 immediately, no clk needed;
//      after release the sequence matches scenario 1.

Source files
------------

// File: rtl/vga_timing_gen.sv
// 640x480@60Hz raster timing generator.
// A clock-enable divides the system clock down to the pixel rate. Coordinates,
// sync and visible-area flags all update together on pixel-enable edges, and
// single-cycle line/frame/game ticks mark the wrap points.
module vga_timing_gen #(
  parameter int DIV       = 4,
  parameter int H_TOTAL   = 800,
  parameter int H_SYNC    = 96,
  parameter int H_VIS_LO  = 144,
  parameter int H_VIS_HI  = 783,
  parameter int V_TOTAL   = 525,
  parameter int V_SYNC    = 2,
  parameter int V_VIS_LO  = 35,
  parameter int V_VIS_HI  = 514,
  parameter int FRAME_DIV = 1
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pix_en,
  output logic [9:0] hCount,
  output logic [9:0] vCount,
  output logic       hSync,
  output logic       vSync,
  output logic       bright,
  output logic       line_tick,
  output logic       frame_tick,
  output logic       game_tick
);

  localparam int DIV_W = $clog2(DIV);
  localparam int FC_W  = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

  logic [DIV_W-1:0] div_cnt;
  logic [FC_W-1:0]  frame_cnt;

  logic       h_last;
  logic       v_last;
  logic       frame_last;
  logic [9:0] h_next;
  logic [9:0] v_next;
  logic       hsync_next;
  logic       vsync_next;
  logic       bright_next;

  // Next-state coordinates; sync and bright are decoded from these so that
  // they land on the same edge as the coordinates they describe.
  always_comb begin
    h_last      = (hCount == 10'(H_TOTAL - 1));
    v_last      = (vCount == 10'(V_TOTAL - 1));
    frame_last  = (frame_cnt == FC_W'(FRAME_DIV - 1));
    h_next      = h_last ? 10'd0 : hCount + 10'd1;
    v_next      = vCount;
    if (h_last) begin
      v_next = v_last ? 10'd0 : vCount + 10'd1;
    end
    hsync_next  = (h_next >= 10'(H_SYNC));
    vsync_next  = (v_next >= 10'(V_SYNC));
    bright_next = (h_next >= 10'(H_VIS_LO)) && (h_next <= 10'(H_VIS_HI)) &&
                  (v_next >= 10'(V_VIS_LO)) && (v_next <= 10'(V_VIS_HI));
  end

  // Pixel-rate divider: pix_en is high for the cycle after div_cnt reaches DIV-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      pix_en  <= 1'b0;
    end else begin
      div_cnt <= (div_cnt == DIV_W'(DIV - 1)) ? '0 : div_cnt + DIV_W'(1);
      pix_en  <= (div_cnt == DIV_W'(DIV - 1));
    end
  end

  // Raster counters and their decoded sync/visible flags; all hold between pixels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hCount <= '0;
      vCount <= '0;
      hSync  <= 1'b0;
      vSync  <= 1'b0;
      bright <= 1'b0;
    end else if (pix_en) begin
      hCount <= h_next;
      vCount <= v_next;
      hSync  <= hsync_next;
      vSync  <= vsync_next;
      bright <= bright_next;
    end
  end

  // Wrap ticks: each is high for exactly the clock after its wrapping pixel edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_tick  <= 1'b0;
      frame_tick <= 1'b0;
      game_tick  <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      line_tick  <= pix_en && h_last;
      frame_tick <= pix_en && h_last && v_last;
      game_tick  <= pix_en && h_last && v_last && frame_last;
      if (pix_en && h_last && v_last) begin
        frame_cnt <= frame_last ? '0 : frame_cnt + FC_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen. One instance uses the default 640x480 timing for the
// divider and first line wrap; a second, scaled-down instance (20x12 raster,
// FRAME_DIV=2) makes whole frames and game ticks short enough to sweep.
module tb_vga_timing_gen;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT instances ----------------
  logic       d_pix_en, d_hsync, d_vsync, d_bright, d_line, d_frame, d_game;
  logic [9:0] d_h, d_v;
  logic       s_pix_en, s_hsync, s_vsync, s_bright, s_line, s_frame, s_game;
  logic [9:0] s_h, s_v;

  vga_timing_gen dut_def (
    .clk(clk), .rst(rst), .pix_en(d_pix_en), .hCount(d_h), .vCount(d_v),
    .hSync(d_hsync), .vSync(d_vsync), .bright(d_bright),
    .line_tick(d_line), .frame_tick(d_frame), .game_tick(d_game)
  );

  vga_timing_gen #(
    .DIV(4), .H_TOTAL(20), .H_SYNC(3), .H_VIS_LO(5), .H_VIS_HI(17),
    .V_TOTAL(12), .V_SYNC(2), .V_VIS_LO(3), .V_VIS_HI(9), .FRAME_DIV(2)
  ) dut_sm (
    .clk(clk), .rst(rst), .pix_en(s_pix_en), .hCount(s_h), .vCount(s_v),
    .hSync(s_hsync), .vSync(s_vsync), .bright(s_bright),
    .line_tick(s_line), .frame_tick(s_frame), .game_tick(s_game)
  );

  // ---------------- checking ----------------
  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  // All outputs of both instances must read zero.
  task automatic check_zero(input string tag);
    check({tag, "_d_pix_en"}, 32'(d_pix_en), 0);
    check({tag, "_d_h"},      32'(d_h), 0);
    check({tag, "_d_v"},      32'(d_v), 0);
    check({tag, "_d_hsync"},  32'(d_hsync), 0);
    check({tag, "_d_vsync"},  32'(d_vsync), 0);
    check({tag, "_d_bright"}, 32'(d_bright), 0);
    check({tag, "_d_line"},   32'(d_line), 0);
    check({tag, "_d_frame"},  32'(d_frame), 0);
    check({tag, "_d_game"},   32'(d_game), 0);
    check({tag, "_s_pix_en"}, 32'(s_pix_en), 0);
    check({tag, "_s_h"},      32'(s_h), 0);
    check({tag, "_s_v"},      32'(s_v), 0);
    check({tag, "_s_hsync"},  32'(s_hsync), 0);
    check({tag, "_s_vsync"},  32'(s_vsync), 0);
    check({tag, "_s_bright"}, 32'(s_bright), 0);
    check({tag, "_s_line"},   32'(s_line), 0);
    check({tag, "_s_frame"},  32'(s_frame), 0);
    check({tag, "_s_game"},   32'(s_game), 0);
  endtask

  // Expected default-instance state k clock edges after reset release.
  // Pixel p is entered on edge 1+4p; pix_en is high after every 4th edge.
  task automatic check_def(input int k);
    int p, h, v;
    p = (k - 1) / 4;
    h = p % 800;
    v = p / 800;
    check("def_pix_en", 32'(d_pix_en), 32'(k % 4 == 0));
    check("def_hcount", 32'(d_h), 32'(h));
    check("def_vcount", 32'(d_v), 32'(v));
    check("def_hsync",  32'(d_hsync), 32'(h >= 96));
    check("def_vsync",  32'(d_vsync), 32'(v >= 2));
    check("def_bright", 32'(d_bright), 32'(h >= 144 && h <= 783 && v >= 35 && v <= 514));
    check("def_line",   32'(d_line), 32'(k > 1 && (k - 1) % 3200 == 0));
    check("def_frame",  32'(d_frame), 0);
    check("def_game",   32'(d_game), 0);
  endtask

  // Expected small-instance state k edges after release: line = 80 clk,
  // frame = 960 clk, game tick every second frame = 1920 clk.
  task automatic check_sm(input int k);
    int p, h, v;
    p = (k - 1) / 4;
    h = p % 20;
    v = (p / 20) % 12;
    check("sm_pix_en", 32'(s_pix_en), 32'(k % 4 == 0));
    check("sm_hcount", 32'(s_h), 32'(h));
    check("sm_vcount", 32'(s_v), 32'(v));
    check("sm_hsync",  32'(s_hsync), 32'(h >= 3));
    check("sm_vsync",  32'(s_vsync), 32'(v >= 2));
    check("sm_bright", 32'(s_bright), 32'(h >= 5 && h <= 17 && v >= 3 && v <= 9));
    check("sm_line",   32'(s_line), 32'(k > 1 && (k - 1) % 80 == 0));
    check("sm_frame",  32'(s_frame), 32'(k > 1 && (k - 1) % 960 == 0));
    check("sm_game",   32'(s_game), 32'(k > 1 && (k - 1) % 1920 == 0));
  endtask

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_zero("rst_async");
    repeat (2) @(negedge clk);
    check_zero("rst_hold");
    rst = 1'b0;
  endtask

  // Step n edges after a release, checking both instances #1 after each edge.
  task automatic run_edges(input int n, input bit do_def, input bit do_sm);
    for (int k = 1; k <= n; k++) begin
      @(posedge clk);
      #1;
      if (do_def) check_def(k);
      if (do_sm)  check_sm(k);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Power-on reset, then the divider start-up and first line wrap at the
    // default timing (wrap to hCount=0,vCount=1 on edge 3201).
    #2;
    apply_reset();
    run_edges(3205, 1'b1, 1'b0);

    // Fresh start: sweep the small raster through four frames, covering every
    // sync/visible boundary, frame ticks and two game ticks.
    apply_reset();
    run_edges(4000, 1'b0, 1'b1);

    // Mid-line reset: stop between pixel edges at hCount=10,vCount=7; assert
    // rst away from any clock edge and expect zeros before the next edge.
    apply_reset();
    run_edges(602, 1'b0, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check_zero("rst_midline");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_edges(12, 1'b1, 1'b1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
